// File: rtl/ac_motor_pkg.sv
// Shared constants and types for the AC motor phase generator.
// Sector geometry and safe reset defaults for the downstream SVM/PWM stage.
package ac_motor_pkg;

    localparam int SECTOR_COUNT    = 6;
    localparam int ANGLE_STEPS_DEF = 384;
    localparam int SECTOR_W        = ANGLE_STEPS_DEF / SECTOR_COUNT;

    localparam logic [7:0] DELAY_SAFE  = 8'hFF;
    localparam logic       MOD_DEFAULT = 1'b1;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

endpackage

// File: rtl/ac_motor_phase_gen_if.sv
// Control/status bundle between the motor control stage and the phase generator.
// The master drives frequency and modulation settings; the slave returns angle, sector and latched settings.
interface ac_motor_phase_gen_if #(
    parameter int RESOLUTION_BITS = 12,
    parameter int ANGLE_STEPS     = 384
);
    localparam int AW  = $clog2(ANGLE_STEPS);
    localparam int SAW = $clog2(ANGLE_STEPS / 6);

    logic [RESOLUTION_BITS-1:0] frequency;
    logic [RESOLUTION_BITS-1:0] amplitude;
    logic                       modulation;
    logic [7:0]                 delay;
    logic                       dir;

    logic [AW-1:0]              angle;
    logic [2:0]                 sector;
    logic [SAW-1:0]             sector_angle;
    logic                       step;
    logic                       running;
    logic [RESOLUTION_BITS-1:0] amp_out;
    logic                       mod_out;
    logic [7:0]                 delay_out;

    modport master (
        output frequency, amplitude, modulation, delay, dir,
        input  angle, sector, sector_angle, step, running, amp_out, mod_out, delay_out
    );

    modport slave (
        input  frequency, amplitude, modulation, delay, dir,
        output angle, sector, sector_angle, step, running, amp_out, mod_out, delay_out
    );

endinterface

// File: rtl/ac_motor_prescaler.sv
// Divides the system clock into a one-cycle tick every PRESCALE cycles.
// The count restarts from 0 after reset so activity is tick-aligned.
module ac_motor_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);
    localparam int            CW      = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/ac_motor_phase_gen.sv
// Turns a period-style frequency into a stepped electrical angle with sector
// decomposition, and re-times modulation settings so they only change at sector entry.
module ac_motor_phase_gen
    import ac_motor_pkg::*;
#(
    parameter int RESOLUTION_BITS = 12,
    parameter int PRESCALE        = 16,
    parameter int ANGLE_STEPS     = 384
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    ac_motor_phase_gen_if.slave  io_ctrl
);
    localparam int RB  = RESOLUTION_BITS;
    localparam int W   = ANGLE_STEPS / SECTOR_COUNT;
    localparam int AW  = $clog2(ANGLE_STEPS);
    localparam int SAW = $clog2(W);

    localparam logic [RB-1:0]  FREQ_STOP  = '1;
    localparam logic [AW-1:0]  ANGLE_MAX  = AW'(ANGLE_STEPS - 1);
    localparam logic [SAW-1:0] SA_MAX     = SAW'(W - 1);
    localparam logic [2:0]     SECTOR_MAX = 3'(SECTOR_COUNT - 1);

    logic           w_tick;
    logic           w_halted;
    logic           w_step;
    logic           w_sector_wrap;
    logic [RB-1:0]  w_freq_next;

    logic [RB-1:0]  r_freq_q;
    logic [RB-1:0]  r_pcnt;
    logic [AW-1:0]  r_angle;
    logic [2:0]     r_sector;
    logic [SAW-1:0] r_sector_angle;
    logic           r_step;
    logic           r_running;
    logic [RB-1:0]  r_amp;
    logic           r_mod;
    logic [7:0]     r_delay;

    ac_motor_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (w_tick)
    );

    assign w_halted      = (r_freq_q == FREQ_STOP);
    assign w_step        = w_tick && !w_halted && (r_pcnt >= r_freq_q);
    // A new period only takes effect once the current interval has completed.
    assign w_freq_next   = (w_step || w_halted) ? io_ctrl.frequency : r_freq_q;
    assign w_sector_wrap = w_step && ((io_ctrl.dir == DIR_REV) ? (r_sector_angle == '0)
                                                               : (r_sector_angle == SA_MAX));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_freq_q       <= FREQ_STOP;
            r_pcnt         <= '0;
            r_angle        <= '0;
            r_sector       <= '0;
            r_sector_angle <= '0;
            r_step         <= 1'b0;
            r_running      <= 1'b0;
            r_amp          <= '0;
            r_mod          <= MOD_DEFAULT;
            r_delay        <= DELAY_SAFE;
        end else begin
            r_freq_q  <= w_freq_next;
            r_running <= (w_freq_next != FREQ_STOP);
            r_step    <= w_step;

            if (w_halted || w_step) begin
                r_pcnt <= '0;
            end else if (w_tick && (r_pcnt != FREQ_STOP)) begin
                r_pcnt <= r_pcnt + 1'b1;
            end

            // Sector and in-sector counters move together so no divider is needed.
            if (w_step) begin
                if (io_ctrl.dir == DIR_REV) begin
                    r_angle <= (r_angle == '0) ? ANGLE_MAX : r_angle - 1'b1;
                    if (r_sector_angle == '0) begin
                        r_sector_angle <= SA_MAX;
                        r_sector       <= (r_sector == '0) ? SECTOR_MAX : r_sector - 1'b1;
                    end else begin
                        r_sector_angle <= r_sector_angle - 1'b1;
                    end
                end else begin
                    r_angle <= (r_angle == ANGLE_MAX) ? '0 : r_angle + 1'b1;
                    if (r_sector_angle == SA_MAX) begin
                        r_sector_angle <= '0;
                        r_sector       <= (r_sector == SECTOR_MAX) ? '0 : r_sector + 1'b1;
                    end else begin
                        r_sector_angle <= r_sector_angle + 1'b1;
                    end
                end
            end

            if (w_halted || w_sector_wrap) begin
                r_amp   <= io_ctrl.amplitude;
                r_mod   <= io_ctrl.modulation;
                r_delay <= io_ctrl.delay;
            end
        end
    end

    assign io_ctrl.angle        = r_angle;
    assign io_ctrl.sector       = r_sector;
    assign io_ctrl.sector_angle = r_sector_angle;
    assign io_ctrl.step         = r_step;
    assign io_ctrl.running      = r_running;
    assign io_ctrl.amp_out      = r_amp;
    assign io_ctrl.mod_out      = r_mod;
    assign io_ctrl.delay_out    = r_delay;

endmodule
